conv_layer_ctrl: RTL and testbench

Layer-level sequencer for the img2col GEMM datapath. It accepts one convolution layer configuration from the host and drives and holds the parameter-preparation block's `start` with that configuration. Once preparation reports `enable`, it schedules every (tensor-block, weight-block) tile pair to the GEMM engine through a valid/ready issue handshake and a completion pulse. It raises a one-cycle done pulse at the end of the layer, then releases the preparation block back to reset.

---
 rtl/conv_layer_ctrl.sv | 143 ++++++++++++++
 tb/tb_conv_layer_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_ctrl.sv
// Layer-level sequencer for the img2col GEMM datapath: holds the preparation
// block in start for a whole layer and walks every (tensor, weight) tile pair.
module conv_layer_ctrl #(
  parameter int TS_W         = 8,
  parameter int KS_W         = 4,
  parameter int CH_W         = 8,
  parameter int ST_W         = 4,
  parameter int KN_W         = 8,
  parameter int BLK_W        = 12,
  parameter int PREP_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             abort,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [TS_W-1:0]  cfg_tensor_size,
  input  logic [KS_W-1:0]  cfg_kernel_size,
  input  logic [CH_W-1:0]  cfg_channels,
  input  logic [ST_W-1:0]  cfg_stride,
  input  logic [KN_W-1:0]  cfg_kernel_nums,
  output logic             prep_start,
  output logic [TS_W-1:0]  tensor_size,
  output logic [KS_W-1:0]  kernel_size,
  output logic [CH_W-1:0]  channels,
  output logic [ST_W-1:0]  stride,
  output logic [KN_W-1:0]  kernel_nums,
  input  logic             prep_enable,
  input  logic [BLK_W-1:0] t_blk_num,
  input  logic [BLK_W-1:0] w_blk_num,
  output logic             tile_valid,
  input  logic             tile_ready,
  output logic [BLK_W-1:0] tile_t_idx,
  output logic [BLK_W-1:0] tile_w_idx,
  output logic             tile_last,
  input  logic             tile_done,
  output logic             busy,
  output logic             layer_done,
  output logic             err_cfg
);

  localparam int WD_W = $clog2(PREP_TIMEOUT);
  localparam logic [BLK_W-1:0] BLK_ONE = BLK_W'(1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(PREP_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, PREP, ISSUE, WAIT, DONE} state_t;

  state_t           state, next_state;
  logic [BLK_W-1:0] t_blk_r, w_blk_r;
  logic [WD_W-1:0]  wdog;
  logic             cfg_bad, blk_zero, wd_expired, last_tile, w_wrap;

  // Kernel wider than the tensor is compared at a common width.
  assign cfg_bad = (cfg_stride == '0) || (cfg_kernel_size == '0) ||
                   (cfg_channels == '0) || (cfg_kernel_nums == '0) ||
                   ({{TS_W{1'b0}}, cfg_kernel_size} > {{KS_W{1'b0}}, cfg_tensor_size});
  assign blk_zero   = (t_blk_num == '0) || (w_blk_num == '0);
  assign wd_expired = (wdog == WD_LAST);
  assign w_wrap     = (tile_w_idx == w_blk_r - BLK_ONE);
  assign last_tile  = (tile_t_idx == t_blk_r - BLK_ONE) && w_wrap;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (cfg_valid && !cfg_bad) next_state = PREP;
        PREP:    if (prep_enable)     next_state = blk_zero ? IDLE : ISSUE;
                 else if (wd_expired) next_state = IDLE;
        ISSUE:   if (tile_ready) next_state = WAIT;
        WAIT:    if (tile_done)  next_state = last_tile ? DONE : ISSUE;
        DONE:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    cfg_ready  = (state == IDLE);
    busy       = (state != IDLE);
    prep_start = (state == PREP) || (state == ISSUE) || (state == WAIT);
    tile_valid = (state == ISSUE);
    tile_last  = (state == ISSUE) && last_tile;
    layer_done = (state == DONE);
  end

  // Abort freezes every register, so err_cfg keeps its value across an abort.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tensor_size <= '0;
      kernel_size <= '0;
      channels    <= '0;
      stride      <= '0;
      kernel_nums <= '0;
      err_cfg     <= 1'b0;
      t_blk_r     <= '0;
      w_blk_r     <= '0;
      tile_t_idx  <= '0;
      tile_w_idx  <= '0;
      wdog        <= '0;
    end else if (!abort) begin
      case (state)
        IDLE: if (cfg_valid) begin
          tensor_size <= cfg_tensor_size;
          kernel_size <= cfg_kernel_size;
          channels    <= cfg_channels;
          stride      <= cfg_stride;
          kernel_nums <= cfg_kernel_nums;
          err_cfg     <= cfg_bad;
          wdog        <= '0;
        end
        PREP: begin
          wdog <= wdog + WD_W'(1);
          if (prep_enable) begin
            t_blk_r    <= t_blk_num;
            w_blk_r    <= w_blk_num;
            tile_t_idx <= '0;
            tile_w_idx <= '0;
            if (blk_zero) err_cfg <= 1'b1;
          end else if (wd_expired) begin
            err_cfg <= 1'b1;
          end
        end
        WAIT: if (tile_done && !last_tile) begin
          if (w_wrap) begin
            tile_w_idx <= '0;
            tile_t_idx <= tile_t_idx + BLK_ONE;
          end else begin
            tile_w_idx <= tile_w_idx + BLK_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Self-checking bench for conv_layer_ctrl: a GEMM-engine model pops expected
// tiles from a scoreboard queue filled when the block counts are presented.
module tb_conv_layer_ctrl;

  localparam int BLK_W = 12;

  typedef struct {
    logic [BLK_W-1:0] t;
    logic [BLK_W-1:0] w;
    logic             last;
  } tile_t;

  logic clk = 1'b0;
  logic rstn, abort, cfg_valid, prep_enable, tile_ready, tile_done;
  logic [7:0] cfg_tensor_size, cfg_channels, cfg_kernel_nums;
  logic [3:0] cfg_kernel_size, cfg_stride;
  logic [BLK_W-1:0] t_blk_num, w_blk_num;
  logic cfg_ready, prep_start, tile_valid, tile_last, busy, layer_done, err_cfg;
  logic [7:0] tensor_size, channels, kernel_nums;
  logic [3:0] kernel_size, stride;
  logic [BLK_W-1:0] tile_t_idx, tile_w_idx;

  tile_t exp_q[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  conv_layer_ctrl #(.PREP_TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn), .abort(abort),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_tensor_size(cfg_tensor_size), .cfg_kernel_size(cfg_kernel_size),
    .cfg_channels(cfg_channels), .cfg_stride(cfg_stride), .cfg_kernel_nums(cfg_kernel_nums),
    .prep_start(prep_start),
    .tensor_size(tensor_size), .kernel_size(kernel_size), .channels(channels),
    .stride(stride), .kernel_nums(kernel_nums),
    .prep_enable(prep_enable), .t_blk_num(t_blk_num), .w_blk_num(w_blk_num),
    .tile_valid(tile_valid), .tile_ready(tile_ready),
    .tile_t_idx(tile_t_idx), .tile_w_idx(tile_w_idx), .tile_last(tile_last),
    .tile_done(tile_done), .busy(busy), .layer_done(layer_done), .err_cfg(err_cfg)
  );

  // Presents one configuration for a single cycle; returns at the following negedge.
  task automatic send_cfg(input int ts, input int ks, input int ch, input int st, input int kn);
    cfg_tensor_size = 8'(ts);
    cfg_kernel_size = 4'(ks);
    cfg_channels    = 8'(ch);
    cfg_stride      = 4'(st);
    cfg_kernel_nums = 8'(kn);
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic start_prep(input int nt, input int nw);
    prep_enable = 1'b1;
    t_blk_num = BLK_W'(nt);
    w_blk_num = BLK_W'(nw);
    for (int t = 0; t < nt; t++)
      for (int w = 0; w < nw; w++)
        exp_q.push_back('{t: BLK_W'(t), w: BLK_W'(w), last: (t == nt - 1) && (w == nw - 1)});
    @(negedge clk);
    checks++;
    if ({tile_valid, tile_t_idx, tile_w_idx} !== {1'b1, {BLK_W{1'b0}}, {BLK_W{1'b0}}}) begin
      errors++;
      $display("[TB] FAIL first_tile: valid=%0b idx=(%0d,%0d) required valid=1 idx=(0,0)",
               tile_valid, tile_t_idx, tile_w_idx);
    end
  endtask

  // GEMM engine model: accepts tiles, optionally stalls one, pulses tile_done 4 cycles later.
  task automatic run_tiles(input int stall_tile, input int stall_len, input int abort_after,
                           output int tiles_seen, output int done_pulses);
    int stall_cnt, wait_cnt;
    bit in_wait, expect_valid, expect_done, cur_last;
    tile_t e;
    tiles_seen = 0; done_pulses = 0; stall_cnt = 0; wait_cnt = 0;
    in_wait = 0; expect_valid = 0; expect_done = 0; cur_last = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      tile_done = 1'b0;
      tile_ready = 1'b0;
      if (expect_valid) begin
        checks++;
        if (tile_valid !== 1'b1) begin
          errors++;
          $display("[TB] FAIL reissue_after_done: tile_valid=%0b required 1", tile_valid);
        end
        expect_valid = 0;
      end
      if (expect_done) begin
        checks++;
        if (layer_done !== 1'b1) begin
          errors++;
          $display("[TB] FAIL done_after_last: layer_done=%0b required 1", layer_done);
        end
        expect_done = 0;
      end
      if (layer_done === 1'b1) begin
        done_pulses++;
        checks++;
        if ({prep_start, tile_valid} !== 2'b00) begin
          errors++;
          $display("[TB] FAIL prep_low_at_done: prep_start=%0b tile_valid=%0b required 0,0",
                   prep_start, tile_valid);
        end
        prep_enable = 1'b0;
        @(negedge clk);
        checks++;
        if ({cfg_ready, busy, layer_done} !== 3'b100) begin
          errors++;
          $display("[TB] FAIL idle_after_done: cfg_ready=%0b busy=%0b layer_done=%0b required 1,0,0",
                   cfg_ready, busy, layer_done);
        end
        return;
      end
      if (tile_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL extra_tile: idx=(%0d,%0d) required no tile", tile_t_idx, tile_w_idx);
          tile_ready = 1'b1;
          in_wait = 1; wait_cnt = 4; cur_last = tile_last;
        end else begin
          e = exp_q[0];
          checks++;
          if ({tile_t_idx, tile_w_idx, tile_last} !== {e.t, e.w, e.last}) begin
            errors++;
            $display("[TB] FAIL tile_order: idx=(%0d,%0d) last=%0b required (%0d,%0d) last=%0b",
                     tile_t_idx, tile_w_idx, tile_last, e.t, e.w, e.last);
          end
          if (tiles_seen == stall_tile && stall_cnt < stall_len) begin
            stall_cnt++;
          end else begin
            void'(exp_q.pop_front());
            cur_last = e.last;
            tiles_seen++;
            tile_ready = 1'b1;
            in_wait = 1; wait_cnt = 4;
          end
        end
      end else if (in_wait) begin
        if (abort_after == tiles_seen) begin
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          prep_enable = 1'b0;
          return;
        end
        wait_cnt--;
        if (wait_cnt == 0) begin
          tile_done = 1'b1;
          in_wait = 0;
          if (cur_last) expect_done = 1; else expect_valid = 1;
        end
      end
    end
    checks++; errors++;
    $display("[TB] FAIL layer_timeout: no layer_done within 400 cycles");
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cfg_ready, prep_start, tile_valid, tile_last, busy, layer_done, err_cfg} !== 7'b1000000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b required 1000000",
               {cfg_ready, prep_start, tile_valid, tile_last, busy, layer_done, err_cfg});
    end
    checks++;
    if ({tensor_size, kernel_size, channels, stride, kernel_nums, tile_t_idx, tile_w_idx} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_values: ts=%0d ks=%0d idx=(%0d,%0d) required all 0",
               tensor_size, kernel_size, tile_t_idx, tile_w_idx);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_layer(input int stall_tile, input int stall_len, input string tag);
    int ts_seen, dp;
    send_cfg(8, 3, 4, 1, 8);
    checks++;
    if ({prep_start, busy, cfg_ready} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL %s_accept: prep_start=%0b busy=%0b cfg_ready=%0b required 1,1,0",
               tag, prep_start, busy, cfg_ready);
    end
    checks++;
    if ({tensor_size, kernel_size, channels, stride, kernel_nums} !== {8'd8, 4'd3, 8'd4, 4'd1, 8'd8}) begin
      errors++;
      $display("[TB] FAIL %s_cfg_regs: ts=%0d ks=%0d ch=%0d st=%0d kn=%0d required 8,3,4,1,8",
               tag, tensor_size, kernel_size, channels, stride, kernel_nums);
    end
    repeat (2) @(negedge clk);
    start_prep(2, 3);
    run_tiles(stall_tile, stall_len, -1, ts_seen, dp);
    checks++;
    if (ts_seen != 6 || dp != 1 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_tile_count: tiles=%0d dones=%0d left=%0d required 6,1,0",
               tag, ts_seen, dp, exp_q.size());
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    checks++;
    if (layer_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_extra_done: layer_done=%0b required 0", tag, layer_done);
    end
  endtask

  task automatic test_invalid_cfg;
    send_cfg(8, 9, 4, 1, 8);
    checks++;
    if ({err_cfg, cfg_ready, prep_start} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL ks_gt_ts: err=%0b cfg_ready=%0b prep_start=%0b required 1,1,0",
               err_cfg, cfg_ready, prep_start);
    end
    send_cfg(8, 3, 4, 0, 8);
    checks++;
    if ({err_cfg, cfg_ready, prep_start} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL stride_zero: err=%0b cfg_ready=%0b prep_start=%0b required 1,1,0",
               err_cfg, cfg_ready, prep_start);
    end
    @(negedge clk);
    checks++;
    if (prep_start !== 1'b0) begin
      errors++;
      $display("[TB] FAIL invalid_no_start: prep_start=%0b required 0", prep_start);
    end
  endtask

  // A valid cfg clears err_cfg; prep_enable is then withheld so the watchdog fires.
  task automatic test_timeout;
    send_cfg(8, 3, 4, 1, 8);
    checks++;
    if ({err_cfg, prep_start} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL err_clear: err=%0b prep_start=%0b required 0,1", err_cfg, prep_start);
    end
    repeat (15) @(negedge clk);
    checks++;
    if ({err_cfg, prep_start} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL timeout_early: at P+15 err=%0b prep_start=%0b required 0,1", err_cfg, prep_start);
    end
    @(negedge clk);
    checks++;
    if ({err_cfg, cfg_ready, prep_start} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL timeout_fire: at P+16 err=%0b cfg_ready=%0b prep_start=%0b required 1,1,0",
               err_cfg, cfg_ready, prep_start);
    end
  endtask

  task automatic test_zero_blocks;
    send_cfg(8, 3, 4, 1, 8);
    prep_enable = 1'b1;
    t_blk_num = BLK_W'(2);
    w_blk_num = '0;
    @(negedge clk);
    checks++;
    if ({err_cfg, cfg_ready, tile_valid} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL zero_blocks: err=%0b cfg_ready=%0b tile_valid=%0b required 1,1,0",
               err_cfg, cfg_ready, tile_valid);
    end
    prep_enable = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (tile_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_blocks_issue: tile_valid=%0b required 0", tile_valid);
    end
  endtask

  task automatic test_one_by_one(input string tag);
    int ts_seen, dp;
    send_cfg(4, 4, 1, 1, 1);
    start_prep(1, 1);
    run_tiles(-1, 0, -1, ts_seen, dp);
    checks++;
    if (ts_seen != 1 || dp != 1 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_1x1: tiles=%0d dones=%0d left=%0d required 1,1,0",
               tag, ts_seen, dp, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_abort;
    int ts_seen, dp;
    send_cfg(8, 3, 4, 1, 8);
    start_prep(2, 3);
    run_tiles(-1, 0, 2, ts_seen, dp);
    checks++;
    if ({cfg_ready, busy, prep_start, tile_valid, layer_done, err_cfg} !== 6'b100000 || ts_seen != 2) begin
      errors++;
      $display("[TB] FAIL abort_idle: rdy=%0b busy=%0b start=%0b valid=%0b done=%0b err=%0b tiles=%0d required 1,0,0,0,0,0,2",
               cfg_ready, busy, prep_start, tile_valid, layer_done, err_cfg, ts_seen);
    end
    exp_q.delete();
    tile_done = 1'b1;
    @(negedge clk);
    tile_done = 1'b0;
    checks++;
    if ({cfg_ready, tile_valid, layer_done} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL spurious_done: rdy=%0b valid=%0b done=%0b required 1,0,0",
               cfg_ready, tile_valid, layer_done);
    end
    test_one_by_one("post_abort");
  endtask

  task automatic test_reset_mid;
    send_cfg(8, 3, 4, 1, 8);
    start_prep(2, 2);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({cfg_ready, prep_start, tile_valid, busy, layer_done, err_cfg} !== 6'b100000 ||
        {tensor_size, tile_t_idx, tile_w_idx} !== '0) begin
      errors++;
      $display("[TB] FAIL async_reset: rdy=%0b start=%0b valid=%0b busy=%0b ts=%0d required 1,0,0,0,0",
               cfg_ready, prep_start, tile_valid, busy, tensor_size);
    end
    prep_enable = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    test_one_by_one("post_reset");
  endtask

  initial begin
    rstn = 1'b0; abort = 1'b0; cfg_valid = 1'b0; prep_enable = 1'b0;
    tile_ready = 1'b0; tile_done = 1'b0;
    cfg_tensor_size = '0; cfg_kernel_size = '0; cfg_channels = '0;
    cfg_stride = '0; cfg_kernel_nums = '0; t_blk_num = '0; w_blk_num = '0;
    test_reset();
    test_basic_layer(-1, 0, "basic");
    test_basic_layer(1, 5, "backpressure");
    test_invalid_cfg();
    test_timeout();
    test_zero_blocks();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
